// File: rtl/read_bram.sv
// read_bram: sweeps a block-RAM address range num_iters times and streams the words out through a 4-slot FIFO.
// Define READ_STALL_COUNT_EN to add the stall_cycles output.
module read_bram #(
    parameter int GROUP_SIZE      = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int LOG_MAX_ADDRESS = 16,
    parameter int LOG_MAX_READS   = 16,
    parameter int LOG_MAX_ITERS   = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             configure,
    input  logic [LOG_MAX_ADDRESS-1:0]       base_address,
    input  logic [LOG_MAX_READS-1:0]         num_reads,
    input  logic [LOG_MAX_ITERS-1:0]         num_iters,
    output logic [LOG_MAX_ADDRESS-1:0]       address_out,
    output logic                             read_out,
    input  logic [GROUP_SIZE*DATA_WIDTH-1:0] data_in,
    output logic [GROUP_SIZE*DATA_WIDTH-1:0] data_out,
    output logic                             valid_out,
    input  logic                             avail_in,
    output logic                             busy
`ifdef READ_STALL_COUNT_EN
    ,
    output logic [31:0]                      stall_cycles
`endif
);
    localparam int W = GROUP_SIZE * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, READING, DRAIN} state_t;

    state_t                     state_q, state_d;
    logic [LOG_MAX_ADDRESS-1:0] base_q, base_d;
    logic [LOG_MAX_READS-1:0]   nreads_q, nreads_d, offset_q, offset_d;
    logic [LOG_MAX_ITERS-1:0]   iters_q, iters_d;
    logic                       inflight_q;
    logic [2:0]                 count_q;
    logic [1:0]                 rd_ptr_q, wr_ptr_q;
    logic [W-1:0]               mem_q [4];
    logic                       accept, last_read, pop;

    assign accept      = state_q == IDLE && configure;
    assign last_read   = offset_q == nreads_q - LOG_MAX_READS'(1);
    assign pop         = count_q != 3'd0 && avail_in;
    assign valid_out   = pop;
    assign busy        = state_q != IDLE;
    assign address_out = base_q + LOG_MAX_ADDRESS'(offset_q);
    assign data_out    = count_q != 3'd0 ? mem_q[rd_ptr_q] : '0;

    // Credits: FIFO entries plus the word still coming back from the RAM never exceed 4.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        nreads_d = nreads_q;
        iters_d  = iters_q;
        offset_d = offset_q;
        read_out = state_q == READING && (count_q + {2'b0, inflight_q}) < 3'd4;
        if (accept) begin
            base_d   = base_address;
            nreads_d = num_reads;
            iters_d  = num_iters;
            offset_d = '0;
            state_d  = (num_reads != '0 && num_iters != '0) ? READING : IDLE;
        end
        if (read_out) begin
            offset_d = last_read ? '0 : offset_q + LOG_MAX_READS'(1);
            if (last_read) begin
                iters_d = iters_q - LOG_MAX_ITERS'(1);
                if (iters_q == LOG_MAX_ITERS'(1)) state_d = DRAIN;
            end
        end
        if (state_q == DRAIN && !inflight_q && count_q == 3'd0) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            nreads_q   <= '0;
            iters_q    <= '0;
            offset_q   <= '0;
            inflight_q <= 1'b0;
            count_q    <= 3'd0;
            rd_ptr_q   <= 2'd0;
            wr_ptr_q   <= 2'd0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            nreads_q   <= nreads_d;
            iters_q    <= iters_d;
            offset_q   <= offset_d;
            inflight_q <= read_out;
            count_q    <= count_q + {2'b0, inflight_q} - {2'b0, pop};
            if (inflight_q) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (inflight_q) mem_q[wr_ptr_q] <= data_in;
    end

`ifdef READ_STALL_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_cycles <= '0;
        else if (accept) stall_cycles <= '0;
        else if (busy && count_q != 3'd0 && !avail_in && stall_cycles != '1)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_read_bram.sv
// tb_read_bram: table-driven bench for read_bram with a 1-cycle-latency RAM model.
module tb_read_bram;
    logic        clk = 1'b0;
    logic        rst, configure, read_out, valid_out, avail_in, busy;
    logic [15:0] base_address, num_reads, num_iters, address_out;
    logic [31:0] data_in, data_out;
`ifdef READ_STALL_COUNT_EN
    logic [31:0] stall_cycles;
`endif
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] base;
        logic [15:0] reads;
        logic [15:0] iters;
        int          stall_len;
        int          recfg;
        int          exp_words;
        int          first_val;
        int          last_val;
    } vec_t;

    vec_t vecs [7];

    read_bram dut (
        .clk(clk), .rst(rst), .configure(configure), .base_address(base_address),
        .num_reads(num_reads), .num_iters(num_iters), .address_out(address_out),
        .read_out(read_out), .data_in(data_in), .data_out(data_out),
        .valid_out(valid_out), .avail_in(avail_in), .busy(busy)
`ifdef READ_STALL_COUNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ram(input logic [15:0] a);
        return {a, ~a};
    endfunction

    always @(posedge clk) data_in <= read_out ? ram(address_out) : 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int nrd = 0, nout = 0, first_c = -1, last_c = -1, rd_at_resume = -1;
        logic [15:0] ea;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            configure    = (cyc == 0) || (cyc == v.recfg);
            base_address = cyc == 0 ? v.base : v.base ^ 16'h0F00;
            num_reads    = cyc == 0 ? v.reads : 16'd1;
            num_iters    = cyc == 0 ? v.iters : 16'd1;
            avail_in     = !(v.stall_len > 0 && cyc >= 3 && cyc < 3 + v.stall_len);
            #1;
            if (v.stall_len > 0 && cyc == 3 + v.stall_len) rd_at_resume = nrd;
            if (read_out) begin
                ea = v.base + 16'(nrd % int'(v.reads));
                check("rd_addr", {16'd0, address_out}, {16'd0, ea});
                nrd++;
            end
            if (valid_out) begin
                ea = v.base + 16'(nout % int'(v.reads));
                check("out_data", data_out, ram(ea));
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                nout++;
            end
            if (cyc > 0 && !busy) break;
        end
        configure = 1'b0;
        check("busy_end", {31'd0, busy}, 32'd0);
        check("num_reads", nrd, v.exp_words);
        check("num_words", nout, v.exp_words);
        check("first_valid", first_c, v.first_val);
        check("last_valid", last_c, v.last_val);
        if (v.stall_len > 0) check("reads_in_stall", rd_at_resume, 4);
`ifdef READ_STALL_COUNT_EN
        check("stall_cycles", stall_cycles, v.stall_len);
`endif
    endtask

    initial begin
        vecs[0] = '{16'h0010, 16'd4, 16'd1, 0,  -1, 4, 3,  6};
        vecs[1] = '{16'h0100, 16'd3, 16'd2, 0,  -1, 6, 3,  8};
        vecs[2] = '{16'h0040, 16'd8, 16'd1, 10, -1, 8, 13, 20};
        vecs[3] = '{16'hFFFE, 16'd4, 16'd1, 0,  -1, 4, 3,  6};
        vecs[4] = '{16'h0020, 16'd0, 16'd3, 0,  -1, 0, -1, -1};
        vecs[5] = '{16'h0020, 16'd5, 16'd0, 0,  -1, 0, -1, -1};
        vecs[6] = '{16'h0200, 16'd5, 16'd1, 0,  2,  5, 3,  7};
        rst = 1'b0; configure = 1'b0; avail_in = 1'b1;
        base_address = 16'd0; num_reads = 16'd0; num_iters = 16'd0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_read", {31'd0, read_out}, 32'd0);
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_addr", {16'd0, address_out}, 32'd0);
        check("rst_data", data_out, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset in the middle of a sweep with two words buffered.
        @(negedge clk);
        configure = 1'b1; base_address = 16'h0040; num_reads = 16'd8; num_iters = 16'd1; avail_in = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            configure = 1'b0;
        end
        #1;
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        avail_in = 1'b1;
        #1;
        check("mid_rst_read", {31'd0, read_out}, 32'd0);
        check("mid_rst_valid", {31'd0, valid_out}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_addr", {16'd0, address_out}, 32'd0);
        check("mid_rst_data", data_out, 32'd0);
`ifdef READ_STALL_COUNT_EN
        check("mid_rst_stall", stall_cycles, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            check("post_rst_quiet", {30'd0, valid_out, read_out}, 32'd0);
        end
        run_vec(vecs[0]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/read_bram.md
Name: read_bram

Overview:
Reader counterpart of the block-RAM writer stage. It issues sequential read requests to a block RAM and buffers the returned words in an internal 4-slot FIFO. It then forwards the words downstream on the codebase valid/avail interface. The configured address sweep is repeated for a programmable number of iterations, so one buffer can feed a multi-pass stage.

Parameters:
GROUP_SIZE, 4, values per memory word
DATA_WIDTH, 8, bits per value; memory word is GROUP_SIZE*DATA_WIDTH
LOG_MAX_ADDRESS, 16, address width
LOG_MAX_READS, 16, width of the reads-per-iteration counter
LOG_MAX_ITERS, 16, width of the iteration counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
configure  in  1  CONFIGURE: one-cycle load strobe
base_address  in  LOG_MAX_ADDRESS  CONFIGURE: first address of each sweep
num_reads  in  LOG_MAX_READS  CONFIGURE: reads per iteration
num_iters  in  LOG_MAX_ITERS  CONFIGURE: number of iterations
address_out  out  LOG_MAX_ADDRESS  MEM: read address
read_out  out  1  MEM: read enable
data_in  in  GROUP_SIZE*DATA_WIDTH  MEM: read data, valid exactly 1 cycle after read_out
data_out  out  GROUP_SIZE*DATA_WIDTH  OUT: data (FIFO head)
valid_out  out  1  OUT: transfer this cycle
avail_in  in  1  OUT: downstream can accept this cycle
busy  out  1  high from accepted configure until fully drained

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE, FIFO emptied, counters and registers 0, in-flight read discarded. Outputs: read_out=0, valid_out=0, busy=0, address_out=0, data_out=0.
- FSM states:
  - IDLE: configure is accepted only here; it is ignored in every other state.
  - On configure, latch base_address, num_reads and num_iters; clear offset.
  - Next state after configure: READING if num_reads!=0 and num_iters!=0; otherwise stay in IDLE (busy stays 0).
  - READING: read_out=1 whenever occupancy + inflight < 4.
    - occupancy = FIFO entries; inflight = read issued last cycle.
    - address_out = base_r + offset_r, truncated to LOG_MAX_ADDRESS (wraps modulo 2^LOG_MAX_ADDRESS).
  - End of sweep: on a read with offset_r == num_reads_r-1, offset_r goes to 0 and iters_r decrements.
    - If iters_r was 1, go to DRAIN.
    - Otherwise the next read restarts at base_r.
  - DRAIN: read_out=0. Return to IDLE when inflight=0 and the FIFO is empty; busy falls in that same transition.
- Return path: read_out at cycle t writes data_in into the FIFO at cycle t+1. The credit rule guarantees no overflow, so no FIFO-full check is needed.
- Output rule: valid_out = ~fifo_empty & avail_in. When valid_out=1, data_out is consumed (FIFO pops) that cycle.
- Latency: configure at cycle 0 -> first read_out at cycle 1 -> word in FIFO at cycle 3 -> valid_out at cycle 3 if avail_in=1.
- Simultaneous FIFO push and pop keep occupancy unchanged.
- With avail_in held high, throughput is one word per cycle.
- avail_in low stalls the output. Reads continue until 4 credits are in use, then read_out=0 until a pop frees a credit.
- Output order equals address issue order: base, base+1, ... base+num_reads-1, repeated num_iters times.

Optional Feature:
READ_STALL_COUNT_EN.
- Defined: adds output stall_cycles [31:0].
  - Counts cycles with busy=1, FIFO non-empty and avail_in=0.
  - Cleared on reset and on an accepted configure; saturates at all ones.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Config base=0x0010, reads=4, iters=1, avail_in=1 -> read_out addresses 0x10..0x13 on cycles 1-4; valid_out cycles 3-6 with RAM contents in order; busy 1 to 0 after the last pop.
- Config base=0x0100, reads=3, iters=2 -> output address sequence 0x100,0x101,0x102,0x100,0x101,0x102; exactly 6 valid_out pulses.
- Config reads=8, avail_in=0 for 10 cycles, then 1 -> exactly 4 reads issued, then read_out=0; no data lost; all 8 words delivered in order; with READ_STALL_COUNT_EN, stall_cycles=10 in the pure-stall window (FIFO non-empty from cycle 3).
- Config base=0xFFFE, reads=4, iters=1 -> addresses 0xFFFE,0xFFFF,0x0000,0x0001.
- Config with reads=0 or iters=0 -> busy stays 0, no read_out, no valid_out; configure during READING -> ignored, sequence unchanged.
- Assert rst=0 mid-READING with 2 words in FIFO -> outputs 0 immediately; after release no stale valid_out; a new configure behaves as from power-up.
